// File: rtl/jcnt_mon.sv
// Johnson counter monitor: decodes each sample to a phase index, tracks sequence
// lock, and pulses err / bumps a saturating counter when a locked sequence breaks.
module jcnt_mon #(
    parameter int W      = 8,
    parameter int PW     = 4,
    parameter int LOCK_N = 4,
    parameter int ECW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld,
    input  logic [W-1:0]   q,
    output logic [PW-1:0]  phase,
    output logic           valid,
    output logic           locked,
    output logic           err,
    output logic [ECW-1:0] err_cnt
);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic [W-1:0]   q_r_q, q_r_d;
    logic           have_prev_q, have_prev_d;
    logic [3:0]     streak_q, streak_d;
    logic           good;

    // Lower half of the cycle has a 1 in the LSB (or is all-zero); upper half has a 0.
    function automatic logic [PW-1:0] dec(input logic [W-1:0] v);
        int pc;
        pc = 0;
        for (int k = 0; k < W; k++) pc += int'(v[k]);
        if (v == '0 || v[0]) return PW'(pc);
        return PW'(2 * W - pc);
    endfunction

    function automatic logic legal(input logic [W-1:0] v);
        int p;
        logic [W-1:0] c;
        p = int'(dec(v));
        for (int k = 0; k < W; k++) begin
            if (p <= W) c[k] = (k < p);
            else        c[k] = (k >= p - W);
        end
        return c == v;
    endfunction

    always_comb begin
        good = have_prev_q && legal(q_r_q) && legal(q) &&
               (int'(dec(q)) == ((int'(dec(q_r_q)) + 1) % (2 * W)));
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = dec(q);
        valid_d     = legal(q);
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        q_r_d       = q_r_q;
        have_prev_d = have_prev_q;
        streak_d    = streak_q;

        if (ld) begin
            have_prev_d = 1'b0;
            streak_d    = '0;
            state_d     = UNLOCKED;
        end else begin
            q_r_d       = q;
            have_prev_d = 1'b1;
            // The first sample after reset or a load has nothing to compare against.
            if (have_prev_q) begin
                case (state_q)
                    UNLOCKED: begin
                        if (good) begin
                            if (int'(streak_q) + 1 == LOCK_N) begin
                                state_d  = LOCKED;
                                streak_d = '0;
                            end else begin
                                streak_d = streak_q + 4'd1;
                            end
                        end else begin
                            streak_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!good) begin
                            err_d    = 1'b1;
                            state_d  = UNLOCKED;
                            streak_d = '0;
                            if (err_cnt_q != {ECW{1'b1}}) err_cnt_d = err_cnt_q + ECW'(1);
                        end
                    end
                    default: state_d = UNLOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            phase_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            q_r_q       <= '0;
            have_prev_q <= 1'b0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            q_r_q       <= q_r_d;
            have_prev_q <= have_prev_d;
            streak_q    <= streak_d;
        end
    end

    assign phase   = phase_q;
    assign valid   = valid_q;
    assign locked  = (state_q == LOCKED);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_jcnt_mon.sv
// Directed bench for jcnt_mon: a default instance and an ECW=2 instance share one
// stimulus stream so the second one shows counter saturation.
module tb_jcnt_mon;

    logic       clk;
    logic       rst_n;
    logic       ld;
    logic [7:0] q;

    logic [3:0] phase, phase2;
    logic       valid, valid2, locked, locked2, err, err2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int nchk = 0;
    int nerr = 0;
    int idx;

    jcnt_mon u_dut (
        .clk(clk), .rst_n(rst_n), .ld(ld), .q(q),
        .phase(phase), .valid(valid), .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    jcnt_mon #(.ECW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .ld(ld), .q(q),
        .phase(phase2), .valid(valid2), .locked(locked2), .err(err2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] jc(input int i);
        logic [7:0] ones;
        ones = 8'hFF;
        if (i <= 8) return 8'((1 << i) - 1);
        return ones << (i - 8);
    endfunction

    task automatic drive(input logic [7:0] qv, input logic ldv);
        q  = qv;
        ld = ldv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_errcnt"}, 32'(err_cnt), 0);
        check({tag, "_errcnt2"}, 32'(err_cnt2), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        ld    = 1'b0;
        q     = 8'h00;
        #2 rst_n = 1'b0;
        #10;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ascending half: lock after the 5th sample
        for (int i = 0; i < 8; i++) begin
            drive(jc(i), 1'b0);
            check("up_phase", 32'(phase), 32'(i));
            check("up_valid", 32'(valid), 1);
            check("up_err", 32'(err), 0);
            check("up_locked", 32'(locked), 32'(i >= 4));
        end

        // Descending half and the wrap back to zero
        for (int i = 8; i <= 16; i++) begin
            drive(jc(i % 16), 1'b0);
            check("dn_phase", 32'(phase), 32'(i % 16));
            check("dn_err", 32'(err), 0);
            check("dn_locked", 32'(locked), 1);
        end

        // Illegal code while locked
        drive(8'h55, 1'b0);
        check("ill_valid", 32'(valid), 0);
        check("ill_phase", 32'(phase), 4);
        check("ill_err", 32'(err), 1);
        check("ill_errcnt", 32'(err_cnt), 1);
        check("ill_errcnt2", 32'(err_cnt2), 1);
        check("ill_locked", 32'(locked), 0);
        // Resume at index 14; first legal sample has an illegal predecessor
        for (int j = 1; j <= 6; j++) begin
            idx = (13 + j) % 16;
            drive(jc(idx), 1'b0);
            check("rl_phase", 32'(phase), 32'(idx));
            check("rl_err", 32'(err), 0);
            check("rl_locked", 32'(locked), 32'(j >= 5));
        end

        // Repeat 00000111
        drive(jc(3), 1'b0);
        check("hold_phase", 32'(phase), 3);
        check("hold_valid", 32'(valid), 1);
        check("hold_err", 32'(err), 1);
        check("hold_errcnt", 32'(err_cnt), 2);
        check("hold_errcnt2", 32'(err_cnt2), 2);
        check("hold_locked", 32'(locked), 0);
        for (int i = 4; i <= 7; i++) begin
            drive(jc(i), 1'b0);
            check("hr_err", 32'(err), 0);
            check("hr_locked", 32'(locked), 32'(i == 7));
        end

        // Reload with 00000001 while locked
        drive(jc(1), 1'b1);
        check("ld_phase", 32'(phase), 1);
        check("ld_valid", 32'(valid), 1);
        check("ld_locked", 32'(locked), 0);
        check("ld_err", 32'(err), 0);
        check("ld_errcnt", 32'(err_cnt), 2);
        for (int i = 2; i <= 6; i++) begin
            drive(jc(i), 1'b0);
            check("lr_err", 32'(err), 0);
            check("lr_locked", 32'(locked), 32'(i == 6));
        end
        idx = 6;

        // Three more faults: wide counter keeps counting, ECW=2 sticks at 3
        for (int f = 0; f < 3; f++) begin
            drive(jc(idx), 1'b0);
            check("sat_err", 32'(err), 1);
            check("sat_err2", 32'(err2), 1);
            check("sat_errcnt", 32'(err_cnt), 32'(3 + f));
            check("sat_errcnt2", 32'(err_cnt2), 3);
            for (int k = 1; k <= 4; k++) begin
                idx = (idx + 1) % 16;
                drive(jc(idx), 1'b0);
            end
            check("sat_relock", 32'(locked), 1);
            check("sat_relock2", 32'(locked2), 1);
        end

        // Asynchronous reset in mid-cycle
        rst_n = 1'b0;
        #1;
        check_zero("async");
        rst_n = 1'b1;
        idx = (idx + 1) % 16;
        drive(jc(idx), 1'b0);
        check("post_phase", 32'(phase), 32'(idx));
        check("post_locked", 32'(locked), 0);
        for (int k = 1; k <= 4; k++) begin
            idx = (idx + 1) % 16;
            drive(jc(idx), 1'b0);
            check("post_locked_n", 32'(locked), 32'(k == 4));
            check("post_err", 32'(err), 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
